// File: rtl/game_pkg.sv
// Shared types and codes for the two-player factorization game controller.
package game_pkg;

  localparam int DIGIT_W = 4;
  localparam int ANS_W   = 3 * DIGIT_W;
  localparam int Q_W     = 24;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_WAIT_Q  = 4'd2,
    ST_ANSWER  = 4'd3,
    ST_CHECK   = 4'd4,
    ST_RESOLVE = 4'd5,
    ST_NEXT    = 4'd6,
    ST_DONE    = 4'd7
  } state_t;

  localparam logic [1:0] J_NONE = 2'b00;
  localparam logic [1:0] J_OK   = 2'b01;
  localparam logic [1:0] J_NG   = 2'b11;
  localparam logic [1:0] J_TMO  = 2'b10;

  localparam logic [1:0] RES_IDLE = 2'b00;
  localparam logic [1:0] RES_OK   = 2'b01;
  localparam logic [1:0] RES_NG   = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with per-requester lockout masks.
// Pointer records the last contested winner; index 0 = P1.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic       upd_en,
  output logic [1:0] grant
);

  logic       ptr;
  logic [1:0] elig;

  assign elig = req & ~lock;

  // On contention the requester opposite the pointer wins.
  always_comb begin
    grant = '0;
    if (elig == 2'b11) grant = ptr ? 2'b01 : 2'b10;
    else               grant = elig;
  end

  always_ff @(posedge CLK) begin
    if (RST)                            ptr <= 1'b0;
    else if (upd_en && elig == 2'b11)   ptr <= ~ptr;
  end

endmodule

// File: rtl/round_arbiter_ctrl.sv
// Game sequencer: question fetch, P1/P2 arbitration onto the shared checker, scoring.
// Optional WRONG_PENALTY_EN: wrong verdicts also decrement the offender's score (floor 0).
module round_arbiter_ctrl
  import game_pkg::*;
#(
  parameter int NUM_Q   = 8,
  parameter int TIMEOUT = 50_000_000,
  parameter int CHK_LAT = 2,
  parameter int SCORE_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic               Q_REQ,
  output logic [7:0]         Q_IDX,
  input  logic               Q_VALID,
  input  logic [23:0]        QUESTION,
  input  logic               P1_SUBMIT,
  input  logic [11:0]        P1_ANS,
  input  logic               P2_SUBMIT,
  input  logic [11:0]        P2_ANS,
  output logic [11:0]        CHK_ANS,
  output logic [23:0]        CHK_Q,
  input  logic [1:0]         CHK_RESULT,
  output logic [SCORE_W-1:0] SCORE1,
  output logic [SCORE_W-1:0] SCORE2,
  output logic [7:0]         ROUND,
  output logic [3:0]         STATE,
  output logic [1:0]         JUDGE,
  output logic               JUDGE_WHO,
  output logic               DONE
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int CHK_W = $clog2(CHK_LAT + 2);
  localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [CHK_W-1:0] CHK_LAST   = CHK_W'(CHK_LAT);
  localparam logic [7:0]       LAST_ROUND = 8'(NUM_Q - 1);

  state_t             state, state_nxt;
  logic [7:0]         round;
  logic [SCORE_W-1:0] score1, score2;
  logic [Q_W-1:0]     chk_q;
  logic [ANS_W-1:0]   ans_l;
  logic [1:0]         judge;
  logic               judge_who;
  logic               win;
  logic [1:0]         lock;
  logic [1:0]         res_l;
  logic [TMR_W-1:0]   timer;
  logic [CHK_W-1:0]   chk_cnt;

  logic               tmo_hit, arb_en;
  logic [1:0]         req, grant;
  logic [ANS_W-1:0]   grant_ans;

  // Timeout takes priority over any submit arriving in the same cycle.
  assign tmo_hit   = (state == ST_ANSWER) && (timer == TMO_LAST);
  assign arb_en    = (state == ST_ANSWER) && !tmo_hit;
  assign req       = arb_en ? {P2_SUBMIT, P1_SUBMIT} : 2'b00;
  assign grant_ans = grant[1] ? P2_ANS : P1_ANS;

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .req    (req),
    .lock   (lock),
    .upd_en (arb_en),
    .grant  (grant)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (START) state_nxt = ST_FETCH;
      ST_FETCH:         state_nxt = ST_WAIT_Q;
      ST_WAIT_Q:        if (Q_VALID) state_nxt = ST_ANSWER;
      ST_ANSWER: begin
        if (tmo_hit)     state_nxt = ST_NEXT;
        else if (|grant) state_nxt = (grant_ans == '0) ? ST_RESOLVE : ST_CHECK;
      end
      ST_CHECK:         if (chk_cnt == CHK_LAST) state_nxt = ST_RESOLVE;
      ST_RESOLVE:       state_nxt = (res_l == RES_OK || lock[~win]) ? ST_NEXT : ST_ANSWER;
      ST_NEXT:          state_nxt = (round == LAST_ROUND) ? ST_DONE : ST_FETCH;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      round     <= '0;
      score1    <= '0;
      score2    <= '0;
      chk_q     <= '0;
      ans_l     <= '0;
      judge     <= J_NONE;
      judge_who <= 1'b0;
      win       <= 1'b0;
      lock      <= '0;
      res_l     <= RES_IDLE;
      timer     <= '0;
      chk_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            round  <= '0;
            score1 <= '0;
            score2 <= '0;
          end
        end
        ST_WAIT_Q: begin
          if (Q_VALID) begin
            chk_q <= QUESTION;
            lock  <= '0;
            timer <= '0;
          end
        end
        ST_ANSWER: begin
          if (tmo_hit) begin
            judge <= J_TMO;
          end else begin
            timer <= timer + 1'b1;
            // An all-zero answer bypasses the checker and stays pre-judged wrong.
            if (|grant) begin
              win     <= grant[1];
              ans_l   <= grant_ans;
              chk_cnt <= '0;
              res_l   <= RES_NG;
            end
          end
        end
        ST_CHECK: begin
          chk_cnt <= chk_cnt + 1'b1;
          if (chk_cnt == CHK_LAST) res_l <= CHK_RESULT;
        end
        ST_RESOLVE: begin
          judge_who <= win;
          if (res_l == RES_OK) begin
            judge <= J_OK;
            if (!win) begin
              if (score1 != '1) score1 <= score1 + 1'b1;
            end else begin
              if (score2 != '1) score2 <= score2 + 1'b1;
            end
          end else begin
            judge     <= J_NG;
            lock[win] <= 1'b1;
`ifdef WRONG_PENALTY_EN
            if (!win) begin
              if (score1 != '0) score1 <= score1 - 1'b1;
            end else begin
              if (score2 != '0) score2 <= score2 - 1'b1;
            end
`endif
          end
        end
        ST_NEXT: round <= round + 1'b1;
        default: ;
      endcase
    end
  end

  assign Q_REQ     = (state == ST_FETCH);
  assign Q_IDX     = (state == ST_FETCH) ? round : '0;
  assign CHK_ANS   = (state == ST_CHECK) ? ans_l : '0;
  assign CHK_Q     = chk_q;
  assign SCORE1    = score1;
  assign SCORE2    = score2;
  assign ROUND     = round;
  assign STATE     = state;
  assign JUDGE     = judge;
  assign JUDGE_WHO = judge_who;
  assign DONE      = (state == ST_DONE);

endmodule

// File: tb/tb_round_arbiter_ctrl.sv
// Self-checking bench for round_arbiter_ctrl: game-level reference model plus directed scenarios.
module tb_round_arbiter_ctrl;

  localparam int NQ  = 2;
  localparam int TMO = 20;
  localparam int LAT = 2;
  localparam int SW  = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic          CLK, RST, START, Q_REQ, Q_VALID, P1_SUBMIT, P2_SUBMIT, JUDGE_WHO, DONE;
  logic [7:0]    Q_IDX, ROUND;
  logic [23:0]   QUESTION, CHK_Q;
  logic [11:0]   P1_ANS, P2_ANS, CHK_ANS;
  logic [1:0]    CHK_RESULT, JUDGE;
  logic [SW-1:0] SCORE1, SCORE2;
  logic [3:0]    STATE;

  round_arbiter_ctrl #(.NUM_Q(NQ), .TIMEOUT(TMO), .CHK_LAT(LAT), .SCORE_W(SW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .Q_REQ(Q_REQ), .Q_IDX(Q_IDX),
    .Q_VALID(Q_VALID), .QUESTION(QUESTION), .P1_SUBMIT(P1_SUBMIT), .P1_ANS(P1_ANS),
    .P2_SUBMIT(P2_SUBMIT), .P2_ANS(P2_ANS), .CHK_ANS(CHK_ANS), .CHK_Q(CHK_Q),
    .CHK_RESULT(CHK_RESULT), .SCORE1(SCORE1), .SCORE2(SCORE2), .ROUND(ROUND),
    .STATE(STATE), .JUDGE(JUDGE), .JUDGE_WHO(JUDGE_WHO), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Question DB: answers valid two cycles after each fetch request.
  logic [23:0] qdb [2];
  int          q_cnt = 0;
  logic [7:0]  q_idx_l = '0;
  initial begin
    qdb[0]   = 24'hABC532;
    qdb[1]   = 24'h123777;
    Q_VALID  = 1'b0;
    QUESTION = '0;
  end
  always @(negedge CLK) if (Q_REQ === 1'b1) begin q_cnt = 2; q_idx_l = Q_IDX; end
  always @(posedge CLK) begin
    #1;
    Q_VALID = 1'b0;
    if (q_cnt > 0) begin
      q_cnt--;
      if (q_cnt == 0) begin Q_VALID = 1'b1; QUESTION = qdb[q_idx_l[0]]; end
    end
  end

  // Answer checker: verdict of the inputs seen LAT cycles earlier.
  function automatic logic [1:0] verdict(input logic [11:0] a, input logic [23:0] q);
    if (a == 12'h000) return 2'b00;
    return (a == q[11:0]) ? 2'b01 : 2'b11;
  endfunction
  logic [1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = 2'b00;
  always @(posedge CLK) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= verdict(CHK_ANS, CHK_Q);
  end
  assign CHK_RESULT = pipe[LAT-1];

  // Reference model: game rules expressed as phases and counters.
  bit          cmp_en = 0;
  int          m_ph, m_round, m_s1, m_s2, m_used, m_left, m_win, m_ptr, m_judge, m_who;
  bit          m_lock [2];
  bit          m_ok;
  logic [11:0] m_ans;
  logic [23:0] m_q;

  task automatic add_score(input int who, input int d);
    if (who == 0) m_s1 = (m_s1 + d > SMAX) ? SMAX : ((m_s1 + d < 0) ? 0 : m_s1 + d);
    else          m_s2 = (m_s2 + d > SMAX) ? SMAX : ((m_s2 + d < 0) ? 0 : m_s2 + d);
  endtask

  task automatic model_step();
    bit e1, e2;
    if (RST) begin
      m_ph = 0; m_round = 0; m_s1 = 0; m_s2 = 0; m_used = 0; m_left = 0;
      m_win = 0; m_ptr = 0; m_judge = 0; m_who = 0; m_lock[0] = 0; m_lock[1] = 0;
      m_ok = 0; m_ans = '0; m_q = '0; cmp_en = 1;
    end else begin
      case (m_ph)
        0, 7: if (START) begin m_ph = 1; m_round = 0; m_s1 = 0; m_s2 = 0; end
        1: m_ph = 2;
        2: if (Q_VALID) begin m_q = QUESTION; m_lock[0] = 0; m_lock[1] = 0; m_used = 0; m_ph = 3; end
        3: begin
          if (m_used == TMO - 1) begin
            m_judge = 2; m_ph = 6;
          end else begin
            m_used++;
            e1 = P1_SUBMIT && !m_lock[0];
            e2 = P2_SUBMIT && !m_lock[1];
            if (e1 || e2) begin
              if (e1 && e2) begin m_win = 1 - m_ptr; m_ptr = m_win; end
              else m_win = e2 ? 1 : 0;
              m_ans = m_win ? P2_ANS : P1_ANS;
              m_ok  = (m_ans != 0) && (m_ans == m_q[11:0]);
              if (m_ans == 0) m_ph = 5;
              else begin m_ph = 4; m_left = LAT + 1; end
            end
          end
        end
        4: begin m_left--; if (m_left == 0) m_ph = 5; end
        5: begin
          m_who = m_win;
          if (m_ok) begin
            m_judge = 1; add_score(m_win, 1); m_ph = 6;
          end else begin
            m_judge = 3; m_lock[m_win] = 1;
`ifdef WRONG_PENALTY_EN
            add_score(m_win, -1);
`endif
            m_ph = m_lock[1 - m_win] ? 6 : 3;
          end
        end
        6: begin m_ph = (m_round == NQ - 1) ? 7 : 1; m_round++; end
        default: m_ph = 0;
      endcase
    end
  endtask

  always @(posedge CLK) model_step();

  always @(negedge CLK) if (cmp_en) begin
    chk("STATE",     STATE,     m_ph);
    chk("Q_REQ",     Q_REQ,     m_ph == 1);
    chk("Q_IDX",     Q_IDX,     (m_ph == 1) ? m_round : 0);
    chk("CHK_ANS",   CHK_ANS,   (m_ph == 4) ? m_ans : 12'h000);
    chk("CHK_Q",     CHK_Q,     m_q);
    chk("SCORE1",    SCORE1,    m_s1);
    chk("SCORE2",    SCORE2,    m_s2);
    chk("ROUND",     ROUND,     m_round);
    chk("JUDGE",     JUDGE,     m_judge);
    chk("JUDGE_WHO", JUDGE_WHO, m_who);
    chk("DONE",      DONE,      m_ph == 7);
  end

  task automatic pulse_start();
    START = 1'b1; @(negedge CLK); START = 1'b0;
  endtask

  task automatic wait_st(input int s, input string tag);
    int n = 0;
    while (STATE !== 4'(s) && n < 300) begin @(negedge CLK); n++; end
    chk({"wait_", tag}, STATE, s);
  endtask

  task automatic sub(input int p, input logic [11:0] a);
    if (p == 1) begin P1_SUBMIT = 1'b1; P1_ANS = a; end
    else        begin P2_SUBMIT = 1'b1; P2_ANS = a; end
    @(negedge CLK);
    P1_SUBMIT = 1'b0; P2_SUBMIT = 1'b0;
  endtask

  task automatic sub_both(input logic [11:0] a1, input logic [11:0] a2);
    P1_SUBMIT = 1'b1; P1_ANS = a1; P2_SUBMIT = 1'b1; P2_ANS = a2;
    @(negedge CLK);
    P1_SUBMIT = 1'b0; P2_SUBMIT = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; START = 1'b0; P1_SUBMIT = 1'b0; P2_SUBMIT = 1'b0; P1_ANS = '0; P2_ANS = '0;
    repeat (3) @(negedge CLK);
    chk("rst_STATE", STATE, 0);
    chk("rst_SCORE1", SCORE1, 0);
    chk("rst_DONE", DONE, 0);
    chk("rst_CHK_Q", CHK_Q, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Game 1: P1 solo correct, then contested round (pointer at P1 -> P2 wins).
    pulse_start();
    wait_st(3, "g1r0_ans");
    sub(1, 12'h532);
    wait_st(6, "g1r0_next");
    chk("g1r0_SCORE1", SCORE1, 1);
    chk("g1r0_JUDGE", JUDGE, 2'b01);
    chk("g1r0_WHO", JUDGE_WHO, 0);
    @(negedge CLK);
    chk("g1r1_ROUND", ROUND, 1);
    chk("g1r1_QREQ", Q_REQ, 1);
    chk("g1r1_QIDX", Q_IDX, 1);
    wait_st(3, "g1r1_ans");
    sub_both(12'h777, 12'h777);
    wait_st(6, "g1r1_next");
    chk("g1r1_WHO", JUDGE_WHO, 1);
    chk("g1r1_SCORE2", SCORE2, 1);
    wait_st(7, "g1_done");
    chk("g1_DONE", DONE, 1);
    chk("g1_ROUND", ROUND, 2);

    // Game 2: restart clears scores; contested round goes to P1; lockout after wrong.
    pulse_start();
    chk("g2_SCORE1_clr", SCORE1, 0);
    chk("g2_SCORE2_clr", SCORE2, 0);
    chk("g2_ROUND_clr", ROUND, 0);
    wait_st(3, "g2r0_ans");
    sub_both(12'h532, 12'h532);
    wait_st(6, "g2r0_next");
    chk("g2r0_WHO", JUDGE_WHO, 0);
    chk("g2r0_SCORE1", SCORE1, 1);
    wait_st(3, "g2r1_ans");
    sub(1, 12'h111);
    wait_st(3, "g2r1_back");
    chk("g2r1_JUDGE_ng", JUDGE, 2'b11);
`ifdef WRONG_PENALTY_EN
    chk("g2r1_SCORE1_pen", SCORE1, 0);
`else
    chk("g2r1_SCORE1_keep", SCORE1, 1);
`endif
    sub(1, 12'h777);
    chk("g2r1_locked", STATE, 3);
    sub(2, 12'h777);
    wait_st(6, "g2r1_next");
    chk("g2r1_SCORE2", SCORE2, 1);
    chk("g2r1_WHO", JUDGE_WHO, 1);
    wait_st(7, "g2_done");

    // Game 3: submit on the timeout cycle is dropped; zero answer and double wrong.
    pulse_start();
    wait_st(3, "g3r0_ans");
    repeat (TMO - 1) @(negedge CLK);
    sub(1, 12'h532);
    chk("g3r0_tmo_state", STATE, 6);
    chk("g3r0_JUDGE", JUDGE, 2'b10);
    chk("g3r0_SCORE1", SCORE1, 0);
    wait_st(3, "g3r1_ans");
    sub(1, 12'h000);
    chk("g3r1_zero_state", STATE, 5);
    chk("g3r1_zero_chk", CHK_ANS, 0);
    @(negedge CLK);
    chk("g3r1_zero_JUDGE", JUDGE, 2'b11);
    sub(2, 12'h111);
    wait_st(6, "g3r1_next");
    chk("g3r1_WHO", JUDGE_WHO, 1);
    chk("g3r1_SCORE2", SCORE2, 0);
    wait_st(7, "g3_done");

    // Game 4: reset during CHECK aborts with everything cleared.
    pulse_start();
    wait_st(3, "g4r0_ans");
    sub(1, 12'h532);
    wait_st(3, "g4r1_ans");
    sub(1, 12'h777);
    chk("g4_in_check", STATE, 4);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("g4_rst_STATE", STATE, 0);
    chk("g4_rst_SCORE1", SCORE1, 0);
    chk("g4_rst_ROUND", ROUND, 0);
    chk("g4_rst_CHK_ANS", CHK_ANS, 0);
    chk("g4_rst_CHK_Q", CHK_Q, 0);
    chk("g4_rst_JUDGE", JUDGE, 0);
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/round_arbiter_ctrl.md
Name: round_arbiter_ctrl

Overview:
- Sequences one two-player factorization game.
- Fetches each question from the question DB and arbitrates P1/P2 answer submissions onto the single shared answer checker.
- Interprets the checker's RESULT and keeps per-player scores over NUM_Q rounds.
- Sits between the key-entry front ends, the question DB and the checker; its outputs feed the LED and score display logic.

Parameters:
- NUM_Q, 8, questions per game (1..255)
- TIMEOUT, 50_000_000, cycles allowed per round before it is abandoned
- CHK_LAT, 2, cycles from driving checker inputs to a valid checker RESULT
- SCORE_W, 8, score counter width

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- START  in  1  pulse; begins a game from IDLE or DONE
- Q_REQ  out  1  one-cycle question fetch request
- Q_IDX  out  8  index of the question being fetched
- Q_VALID  in  1  QUESTION is valid this cycle
- QUESTION  in  24  [11:0] = three answer digits, [23:12] = display data
- P1_SUBMIT  in  1  P1 submit pulse
- P1_ANS  in  12  P1 digits {d3,d2,d1}, 4 bits each
- P2_SUBMIT  in  1  P2 submit pulse
- P2_ANS  in  12  P2 digits {d3,d2,d1}, 4 bits each
- CHK_ANS  out  12  to checker ANSWER_3/2/1
- CHK_Q  out  24  to checker QUESTION
- CHK_RESULT  in  2  checker output: 00 = idle, 01 = correct, 11 = wrong
- SCORE1  out  SCORE_W  P1 score
- SCORE2  out  SCORE_W  P2 score
- ROUND  out  8  current round index
- STATE  out  4  current FSM state encoding
- JUDGE  out  2  last verdict: 00 none, 01 correct, 11 wrong, 10 timeout
- JUDGE_WHO  out  1  player of last verdict (0 = P1)
- DONE  out  1  high in DONE state

Behaviour:
- Reset values: every output is 0; FSM enters IDLE; lockouts cleared; RR pointer set to P1.
- RST asserted mid-game aborts the game immediately. No partial score updates; all values as above on the next edge.
- FSM encoding:
  - IDLE = 0
  - FETCH = 1: Q_REQ high for exactly one cycle, Q_IDX = ROUND
  - WAIT_Q = 2: on Q_VALID, latch QUESTION into CHK_Q, clear lockouts and timer
  - ANSWER = 3: timer counts
  - CHECK = 4
  - RESOLVE = 5
  - NEXT = 6
  - DONE = 7
- IDLE/DONE + START -> FETCH; ROUND and both scores clear when leaving via START.
- ANSWER:
  - Submit pulses from unlocked players are eligible; pulses in any other state, or from locked players, are dropped. There is no queueing.
  - Both eligible in the same cycle: the player opposite the RR pointer wins. The pointer then points at the winner.
  - The loser's submission is dropped; that player must resubmit.
  - Winner's answer latched; go to CHECK.
  - Latched answer == 12'h000: skip the checker, treat as wrong, go straight to RESOLVE. The checker reports 00 for all-zero input.
- CHECK:
  - CHK_ANS driven with the latched answer for CHK_LAT+1 cycles.
  - CHK_RESULT sampled on the final cycle.
  - Round timer is frozen during CHECK.
- RESOLVE, one cycle; CHK_ANS forced to 0 from this cycle on:
  - 01: winner's score +1, saturating at 2^SCORE_W-1; JUDGE = 01; go to NEXT.
  - 11 (or 00, treated as wrong): lock out the winner; JUDGE = 11. If the other player is also locked, go to NEXT; else return to ANSWER with the timer continuing.
- Timeout: timer reaching TIMEOUT-1 in ANSWER -> JUDGE = 10, go to NEXT. A submit in that same cycle is dropped; timeout wins.
- NEXT:
  - ROUND+1.
  - ROUND == NUM_Q-1 before the increment -> DONE; else -> FETCH.
- CHK_ANS is 0 outside CHECK, so the checker idles with RESULT 00.
- Q_VALID outside WAIT_Q is ignored. WAIT_Q has no timeout.

Optional Feature:
- Macro: WRONG_PENALTY_EN.
- Defined: a wrong verdict in RESOLVE also decrements the offender's score, saturating at 0.
- Undefined: a wrong verdict only locks the player out; scores never decrease.

Decomposition:
- Package game_pkg holds:
  - state enum (4-bit)
  - JUDGE codes
  - checker RESULT codes (RES_IDLE = 00, RES_OK = 01, RES_NG = 11)
  - digit-field widths
- One sub-module, rr_arb2: 2-way round-robin arbiter with lockout mask inputs and a pointer-update enable.

Test Plan:
- NUM_Q=2. START; Q_VALID with QUESTION[11:0]=12'h532; P1 submits 12'h532; checker RESULT 01 after CHK_LAT -> SCORE1=1, JUDGE=01, JUDGE_WHO=0, ROUND=1, Q_REQ re-pulses with Q_IDX=1.
- P1 and P2 submit in the same cycle, first round -> P2 granted (pointer starts at P1). Repeat next round -> P1 granted.
- P1 submits wrong 12'h111 (RESULT 11) -> P1 locked and further P1 submits ignored; P2 then submits correct -> SCORE2=1, SCORE1=0 (1 and 0 saturating with WRONG_PENALTY_EN).
- TIMEOUT=20, no submits -> JUDGE=10 at cycle 20 of ANSWER, scores unchanged, next FETCH.
- P1 submits 12'h000 -> CHK_ANS stays 0, P1 locked, JUDGE=11 within one cycle; P2 wrong as well -> NEXT.
- RST asserted during CHECK -> next edge: STATE=0, all outputs 0. After NUM_Q rounds -> DONE=1; START restarts with cleared scores.
